// File: rtl/xbar_pkg.sv
// xbar_pkg: shared definitions for the 2x2 switch-matrix arbiter.
//   - Master/slave bundle widths and field positions.
//   - Packed views of the master and slave bundles.
//   - Arbiter state encoding (IDLE/BUSY).
//   - Helpers to unpack a raw master bundle and decode its target slave.
package xbar_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned M_W    = 66;
    localparam int unsigned S_W    = 33;

    // Master bundle field positions
    localparam int unsigned M_REQ     = 65;
    localparam int unsigned M_WE      = 64;
    localparam int unsigned M_ADDR_HI = 63;
    localparam int unsigned M_ADDR_LO = 32;

    // Slave response field positions
    localparam int unsigned S_ACK = 32;

    // Address bit that picks the target slave
    localparam int unsigned ADDR_SEL_BIT = 31;

    // Per-slave arbiter state encoding
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    typedef struct packed {
        logic              req;
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } m_bundle_t;

    typedef struct packed {
        logic              ack;
        logic [DATA_W-1:0] rdata;
    } s_bundle_t;

    // Split a raw master bundle into named fields.
    function automatic m_bundle_t unpack_m(input logic [M_W-1:0] raw);
        m_bundle_t b;
        b.req   = raw[M_REQ];
        b.we    = raw[M_WE];
        b.addr  = raw[M_ADDR_HI:M_ADDR_LO];
        b.wdata = raw[M_ADDR_LO-1:0];
        return b;
    endfunction

    // Split a raw slave response into named fields.
    function automatic s_bundle_t unpack_s(input logic [S_W-1:0] raw);
        s_bundle_t b;
        b.ack   = raw[S_ACK];
        b.rdata = raw[S_ACK-1:0];
        return b;
    endfunction

    // True when the master is requesting the given slave.
    function automatic logic targets(input m_bundle_t b, input logic slave);
        return b.req && (b.addr[ADDR_SEL_BIT] == slave);
    endfunction

endpackage

// File: rtl/xbar_slave_arb.sv
// xbar_slave_arb: round-robin arbiter for one slave of the 2x2 matrix.
// Requests and ack are sampled into a register stage first; the FSM acts
// on the sampled values one edge later.
// Ports:
//   clk, rst  clock, asynchronous active-high reset
//   req[1:0]  master x is requesting this slave (already address-decoded)
//   ack       slave acknowledge
//   sel       current/last owner (0 = master 0, 1 = master 1)
//   busy      slave currently granted
//   gnt[1:0]  one-hot: master x holds this slave
//   err       one-cycle pulse when a grant is released by timeout
module xbar_slave_arb
    import xbar_pkg::*;
#(
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned CNT_W   = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       ack,
    output logic       sel,
    output logic       busy,
    output logic [1:0] gnt,
    output logic       err
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [1:0]       req_q;
    logic             ack_q;
    logic [0:0]       state;
    logic [0:0]       state_nx;
    logic             prio;
    logic             prio_nx;
    logic             owner;
    logic             owner_nx;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nx;
    logic             err_nx;
    logic [1:0]       gnt_nx;
    logic             owner_req;

    // Input sample stage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_q <= 2'b00;
            ack_q <= 1'b0;
        end else begin
            req_q <= req;
            ack_q <= ack;
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            prio  <= 1'b0;
            owner <= 1'b0;
            cnt   <= '0;
            err   <= 1'b0;
            gnt   <= 2'b00;
        end else begin
            state <= state_nx;
            prio  <= prio_nx;
            owner <= owner_nx;
            cnt   <= cnt_nx;
            err   <= err_nx;
            gnt   <= gnt_nx;
        end
    end

    // Next-state logic; exit priority in BUSY is ack, abort, timeout
    always_comb begin
        state_nx  = state;
        prio_nx   = prio;
        owner_nx  = owner;
        cnt_nx    = cnt;
        err_nx    = 1'b0;
        owner_req = owner ? req_q[1] : req_q[0];

        case (state)
            IDLE: begin
                if (|req_q) begin
                    state_nx = BUSY;
                    owner_nx = (&req_q) ? prio : req_q[1];
                    cnt_nx   = '0;
                end
            end
            BUSY: begin
                if (ack_q) begin
                    state_nx = IDLE;
                    prio_nx  = ~owner;
                end else if (!owner_req) begin
                    state_nx = IDLE;
                end else if (cnt == CNT_LAST) begin
                    state_nx = IDLE;
                    err_nx   = 1'b1;
                    prio_nx  = ~owner;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase

        // Grant vector registered alongside the state so it lines up with busy
        gnt_nx = 2'b00;
        if (state_nx == BUSY) begin
            gnt_nx = owner_nx ? 2'b10 : 2'b01;
        end
    end

    // sel only moves on a grant, so it holds the last owner while idle
    assign sel  = owner;
    assign busy = (state == BUSY);

endmodule

// File: rtl/xbar_arbiter.sv
// xbar_arbiter: drives the select inputs of the 2x2 master/slave matrix.
// Decodes each master's target slave from addr[31] and runs one
// round-robin arbiter per slave.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   in_0_m, in_1_m    master bundles {req, we, addr[31:0], wdata[31:0]}
//   in0_s, in1_s      slave responses {ack, rdata[31:0]}
//   sel0, sel1        slave owner selects into the matrix
//   busy0, busy1      slave currently granted
//   gnt_0_m, gnt_1_m  master holds a grant on either slave
//   err0, err1        one-cycle pulse on grant release by timeout
module xbar_arbiter
    import xbar_pkg::*;
#(
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned CNT_W   = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [M_W-1:0] in_0_m,
    input  logic [M_W-1:0] in_1_m,
    input  logic [S_W-1:0] in0_s,
    input  logic [S_W-1:0] in1_s,
    output logic           sel0,
    output logic           sel1,
    output logic           busy0,
    output logic           busy1,
    output logic           gnt_0_m,
    output logic           gnt_1_m,
    output logic           err0,
    output logic           err1
);

    m_bundle_t  m0;
    m_bundle_t  m1;
    s_bundle_t  s0;
    s_bundle_t  s1;
    logic [1:0] req_s0;
    logic [1:0] req_s1;
    logic [1:0] gnt_s0;
    logic [1:0] gnt_s1;
    logic       unused_bits;

    assign m0 = unpack_m(in_0_m);
    assign m1 = unpack_m(in_1_m);
    assign s0 = unpack_s(in0_s);
    assign s1 = unpack_s(in1_s);

    // Per-slave request vectors, bit x = master x
    assign req_s0 = {targets(m1, 1'b0), targets(m0, 1'b0)};
    assign req_s1 = {targets(m1, 1'b1), targets(m0, 1'b1)};

    // Data fields pass straight through the matrix, not through here
    assign unused_bits = ^{m0, m1, s0, s1};

    xbar_slave_arb #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_arb0 (
        .clk  (clk),
        .rst  (rst),
        .req  (req_s0),
        .ack  (s0.ack),
        .sel  (sel0),
        .busy (busy0),
        .gnt  (gnt_s0),
        .err  (err0)
    );

    xbar_slave_arb #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_arb1 (
        .clk  (clk),
        .rst  (rst),
        .req  (req_s1),
        .ack  (s1.ack),
        .sel  (sel1),
        .busy (busy1),
        .gnt  (gnt_s1),
        .err  (err1)
    );

    // A master targets one slave at a time, so at most one term is set
    assign gnt_0_m = gnt_s0[0] | gnt_s1[0];
    assign gnt_1_m = gnt_s0[1] | gnt_s1[1];

endmodule

// File: tb/tb_xbar_arbiter.sv
// tb_xbar_arbiter: directed + randomized bench for xbar_arbiter with a
// cycle-level reference model built from the arbitration rules.
module tb_xbar_arbiter;

    localparam int TIMEOUT = 8;
    localparam int CNT_W   = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [65:0] in_0_m;
    logic [65:0] in_1_m;
    logic [32:0] in0_s;
    logic [32:0] in1_s;
    logic        sel0, sel1, busy0, busy1, gnt_0_m, gnt_1_m, err0, err1;

    // Stimulus drive variables
    logic        d_req[2];
    logic        d_we[2];
    logic [31:0] d_addr[2];
    logic [31:0] d_wdata[2];
    logic        d_ack[2];
    logic [31:0] d_rdata[2];

    // Reference model
    logic m_busy[2];
    logic m_owner[2];
    logic m_prio[2];
    logic m_err[2];
    int   m_gedge[2];
    int   edge_n;
    logic p_req[2][2];
    logic p_ack[2];

    int checks = 0;
    int errors = 0;

    assign in_0_m = {d_req[0], d_we[0], d_addr[0], d_wdata[0]};
    assign in_1_m = {d_req[1], d_we[1], d_addr[1], d_wdata[1]};
    assign in0_s  = {d_ack[0], d_rdata[0]};
    assign in1_s  = {d_ack[1], d_rdata[1]};

    always #5 clk = ~clk;

    xbar_arbiter #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .in_0_m  (in_0_m),
        .in_1_m  (in_1_m),
        .in0_s   (in0_s),
        .in1_s   (in1_s),
        .sel0    (sel0),
        .sel1    (sel1),
        .busy0   (busy0),
        .busy1   (busy1),
        .gnt_0_m (gnt_0_m),
        .gnt_1_m (gnt_1_m),
        .err0    (err0),
        .err1    (err1)
    );

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %b expected %b", tag, obs, exp);
        end
    endtask

    function automatic logic wants(input int m, input int s);
        return d_req[m] && (d_addr[m][31] == s[0]);
    endfunction

    function automatic logic exp_gnt(input logic x);
        return (m_busy[0] && m_owner[0] == x) || (m_busy[1] && m_owner[1] == x);
    endfunction

    task automatic model_reset();
        for (int s = 0; s < 2; s++) begin
            m_busy[s]  = 1'b0;
            m_owner[s] = 1'b0;
            m_prio[s]  = 1'b0;
            m_err[s]   = 1'b0;
            m_gedge[s] = 0;
            p_ack[s]   = 1'b0;
            p_req[s][0] = 1'b0;
            p_req[s][1] = 1'b0;
        end
    endtask

    // One clock edge of the rules: decisions use what was sampled last edge
    task automatic model_edge();
        logic o;
        edge_n++;
        for (int s = 0; s < 2; s++) begin
            m_err[s] = 1'b0;
            if (m_busy[s]) begin
                o = m_owner[s];
                if (p_ack[s]) begin
                    m_busy[s] = 1'b0;
                    m_prio[s] = ~o;
                end else if (!p_req[s][o]) begin
                    m_busy[s] = 1'b0;
                end else if (edge_n - m_gedge[s] == TIMEOUT) begin
                    m_busy[s] = 1'b0;
                    m_err[s]  = 1'b1;
                    m_prio[s] = ~o;
                end
            end else if (p_req[s][0] || p_req[s][1]) begin
                m_owner[s] = (p_req[s][0] && p_req[s][1]) ? m_prio[s] : p_req[s][1];
                m_busy[s]  = 1'b1;
                m_gedge[s] = edge_n;
            end
        end
        for (int s = 0; s < 2; s++) begin
            p_req[s][0] = wants(0, s);
            p_req[s][1] = wants(1, s);
            p_ack[s]    = d_ack[s];
        end
    endtask

    task automatic check_all();
        chk("sel0", sel0, m_owner[0]);
        chk("sel1", sel1, m_owner[1]);
        chk("busy0", busy0, m_busy[0]);
        chk("busy1", busy1, m_busy[1]);
        chk("gnt_0_m", gnt_0_m, exp_gnt(1'b0));
        chk("gnt_1_m", gnt_1_m, exp_gnt(1'b1));
        chk("err0", err0, m_err[0]);
        chk("err1", err1, m_err[1]);
    endtask

    task automatic tick();
        if (rst) model_reset();
        else model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    // Advance until the model shows a fresh grant on slave s
    task automatic wait_grant(input int s, input string tag);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!(m_busy[s] && m_gedge[s] == edge_n) && n < 12);
        if (!(m_busy[s] && m_gedge[s] == edge_n)) begin
            checks++;
            errors++;
            $error("FAIL %s_wait observed no grant expected grant within 12 edges", tag);
        end
    endtask

    task automatic all_idle();
        d_req[0] = 1'b0;
        d_req[1] = 1'b0;
        d_ack[0] = 1'b0;
        d_ack[1] = 1'b0;
    endtask

    initial begin
        rst    = 1'b1;
        edge_n = 0;
        for (int i = 0; i < 2; i++) begin
            d_req[i]   = 1'b0;
            d_we[i]    = 1'b0;
            d_addr[i]  = 32'h0;
            d_wdata[i] = $urandom();
            d_ack[i]   = 1'b0;
            d_rdata[i] = $urandom();
        end
        model_reset();

        // Reset state
        tick();
        tick();
        chk("rst_busy0", busy0, 1'b0);
        chk("rst_sel0", sel0, 1'b0);
        rst = 1'b0;
        tick();

        // Single request: grant one edge after it is sampled, release after ack
        d_req[0]  = 1'b1;
        d_addr[0] = 32'h0000_1000;
        tick();
        chk("single_not_yet", busy0, 1'b0);
        tick();
        chk("single_busy", busy0, 1'b1);
        chk("single_sel", sel0, 1'b0);
        chk("single_gnt", gnt_0_m, 1'b1);
        tick();
        tick();
        d_ack[0] = 1'b1;
        tick();
        chk("single_hold", busy0, 1'b1);
        d_ack[0] = 1'b0;
        d_req[0] = 1'b0;
        tick();
        chk("single_release", busy0, 1'b0);
        tick();

        // Fresh reset so contention starts from prio = master 0
        rst = 1'b1;
        model_reset();
        tick();
        rst = 1'b0;
        tick();

        // Contention: grants alternate m0, m1, m0, m1
        d_req[0]  = 1'b1;
        d_addr[0] = 32'h0000_0000;
        d_req[1]  = 1'b1;
        d_addr[1] = 32'h0000_0000;
        for (int g = 0; g < 4; g++) begin
            wait_grant(0, "rr");
            chk("rr_sel0", sel0, g[0]);
            tick();
            tick();
            d_ack[0] = 1'b1;
            tick();
            d_ack[0] = 1'b0;
        end
        all_idle();
        repeat (3) tick();

        // Parallel grants to different masters on both slaves
        d_req[0]  = 1'b1;
        d_addr[0] = 32'h8000_0000;
        d_req[1]  = 1'b1;
        d_addr[1] = 32'h0000_0004;
        tick();
        tick();
        chk("par_sel1", sel1, 1'b0);
        chk("par_sel0", sel0, 1'b1);
        chk("par_busy0", busy0, 1'b1);
        chk("par_busy1", busy1, 1'b1);
        chk("par_gnt0", gnt_0_m, 1'b1);
        chk("par_gnt1", gnt_1_m, 1'b1);
        // Ack together with withdrawal counts as ack
        d_ack[0] = 1'b1;
        d_ack[1] = 1'b1;
        d_req[0] = 1'b0;
        d_req[1] = 1'b0;
        tick();
        all_idle();
        tick();
        tick();

        // Timeout on slave 1, no ack ever
        d_req[1]  = 1'b1;
        d_addr[1] = 32'h8000_0000;
        wait_grant(1, "to");
        chk("to_sel1", sel1, 1'b1);
        for (int i = 1; i < TIMEOUT; i++) begin
            tick();
            chk("to_held", busy1, 1'b1);
            chk("to_no_err", err1, 1'b0);
        end
        tick();
        chk("to_release", busy1, 1'b0);
        chk("to_err", err1, 1'b1);
        d_req[1] = 1'b0;
        tick();
        chk("to_err_pulse", err1, 1'b0);
        repeat (3) tick();
        // prio rotated to m0 by the timeout
        d_req[0]  = 1'b1;
        d_addr[0] = 32'h8000_0000;
        d_req[1]  = 1'b1;
        d_addr[1] = 32'h8000_0010;
        wait_grant(1, "to_tie");
        chk("to_tie_m0", sel1, 1'b0);
        all_idle();
        repeat (3) tick();

        // Abort: withdrawal releases without err and keeps prio
        d_req[0]  = 1'b1;
        d_addr[0] = 32'h0000_0100;
        wait_grant(0, "ab");
        chk("ab_sel0", sel0, 1'b0);
        tick();
        tick();
        d_req[0] = 1'b0;
        tick();
        chk("ab_still", busy0, 1'b1);
        tick();
        chk("ab_release", busy0, 1'b0);
        chk("ab_no_err", err0, 1'b0);
        tick();
        d_req[0]  = 1'b1;
        d_addr[0] = 32'h0000_0200;
        d_req[1]  = 1'b1;
        d_addr[1] = 32'h0000_0300;
        wait_grant(0, "ab_tie");
        chk("ab_tie_m0", sel0, 1'b0);
        d_ack[0] = 1'b1;
        tick();
        d_ack[0] = 1'b0;
        wait_grant(0, "ab_rr");
        chk("ab_rr_m1", sel0, 1'b1);

        // Asynchronous reset mid-grant clears outputs without a clock edge
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        chk("arst_sel0", sel0, 1'b0);
        chk("arst_busy0", busy0, 1'b0);
        chk("arst_gnt1", gnt_1_m, 1'b0);
        chk("arst_gnt0", gnt_0_m, 1'b0);
        chk("arst_err0", err0, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        wait_grant(0, "arst_tie");
        chk("arst_tie_m0", sel0, 1'b0);
        all_idle();
        repeat (3) tick();

        // Randomized traffic against the model
        for (int c = 0; c < 600; c++) begin
            for (int m = 0; m < 2; m++) begin
                if ($urandom_range(0, 99) < 20) d_req[m] = ~d_req[m];
                if ($urandom_range(0, 99) < 10) d_addr[m] = $urandom();
                d_we[m]    = 1'($urandom_range(0, 1));
                d_wdata[m] = $urandom();
            end
            for (int s = 0; s < 2; s++) begin
                d_ack[s]   = ($urandom_range(0, 99) < 12);
                d_rdata[s] = $urandom();
            end
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
